// File: rtl/mt_noc_pkg.sv
// Shared types and constants for the MouseTrap injection path.
// Holds the arbiter state encoding and synchronizer depth.
package mt_noc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_ACK
  } mt_state_t;

  localparam int DATA_W_DEF  = 32;
  localparam int SYNC_STAGES = 2;

  function automatic int rr_next(
    input int ptr,
    input int k,
    input int n
  );
    return (ptr + k) % n;
  endfunction

endpackage

// File: rtl/mt_ack_sync.sv
// Multi-flop synchronizer bringing the async-stage ack into clk.
// Resets asynchronously to 0 so req/ack parity restarts at 0/0.
module mt_ack_sync
  import mt_noc_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= STAGES'({sync, d});
    end
  end

  assign q = sync[STAGES-1];

endmodule

// File: rtl/mt_inject_arbiter.sv
// Round-robin injector from clocked requesters into a two-phase MouseTrap pipe.
// Define MT_INJECT_TIMEOUT_EN to build the sticky WAIT_ACK watchdog on err.
module mt_inject_arbiter
  import mt_noc_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                     clk,
  input  logic                     extReset,
  input  logic [NREQ-1:0]          in_valid,
  input  logic [NREQ*DATA_W-1:0]   in_data,
  output logic [NREQ-1:0]          in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_req,
  input  logic                     out_ack,
  output logic [$clog2(NREQ)-1:0]  out_src,
  output logic                     err
);

  localparam int SRC_W = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("mt_inject_arbiter: parameter out of range");
  end

  mt_state_t        state;
  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] pick;
  logic             any_valid;
  logic             ack_s;

  mt_ack_sync #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk   (clk),
    .rst_n (extReset),
    .d     (out_ack),
    .q     (ack_s)
  );

  assign any_valid = |in_valid;

  // First valid requester strictly after the last winner.
  always_comb begin
    logic             found;
    logic [SRC_W-1:0] idx;
    pick  = rr_ptr;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = SRC_W'(rr_next(int'(rr_ptr), k, NREQ));
      if (!found && in_valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (extReset && state == ST_IDLE && any_valid) begin
      in_ready = NREQ'(1) << pick;
    end
  end

  always_ff @(posedge clk or negedge extReset) begin
    if (!extReset) begin
      state    <= ST_IDLE;
      out_req  <= 1'b0;
      out_data <= '0;
      out_src  <= '0;
      rr_ptr   <= SRC_W'(NREQ - 1);
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (any_valid) begin
            out_data <= in_data[pick*DATA_W +: DATA_W];
            out_src  <= pick;
            rr_ptr   <= pick;
            state    <= ST_LAUNCH;
          end
        end
        // Data already settled for a full cycle before this edge.
        ST_LAUNCH: begin
          out_req <= ~out_req;
          state   <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (ack_s == out_req) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MT_INJECT_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wdog;

  always_ff @(posedge clk or negedge extReset) begin
    if (!extReset) begin
      wdog <= '0;
      err  <= 1'b0;
    end else if (state == ST_LAUNCH) begin
      wdog <= '0;
    end else if (state == ST_WAIT_ACK) begin
      if (wdog != WD_W'(TIMEOUT_CYC)) begin
        wdog <= wdog + 1'b1;
      end
      if (wdog == WD_W'(TIMEOUT_CYC - 1)) begin
        err <= 1'b1;
      end
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mt_inject_arbiter.sv
// Self-checking bench for mt_inject_arbiter with a transaction-level model.
// Ack is driven by an echo model with configurable delay or held manually.
module tb_mt_inject_arbiter;
  import mt_noc_pkg::*;

  localparam int NREQ   = 4;
  localparam int DATA_W = 32;
  localparam int TMO    = 8;
  localparam int SW     = $clog2(NREQ);
`ifdef MT_INJECT_TIMEOUT_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   extReset;
  logic [NREQ-1:0]        in_valid;
  logic [NREQ*DATA_W-1:0] in_data;
  logic [NREQ-1:0]        in_ready;
  logic [DATA_W-1:0]      out_data;
  logic                   out_req;
  logic                   out_ack;
  logic [SW-1:0]          out_src;
  logic                   err;

  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;
  bit   auto_ack = 1'b0;
  int   ack_delay = 0;
  int   ack_cnt   = 0;
  logic seen_req  = 1'b0;

  always #5 clk = ~clk;

  mt_inject_arbiter #(
    .NREQ        (NREQ),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk      (clk),
    .extReset (extReset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_req  (out_req),
    .out_ack  (out_ack),
    .out_src  (out_src),
    .err      (err)
  );

  function automatic logic [NREQ-1:0] oh(input int i);
    return NREQ'(1) << i;
  endfunction

  function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // One clock; the async stage echoes out_req d cycles after it flips.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    if (auto_ack) begin
      if (out_req !== seen_req) begin
        seen_req = out_req;
        if (ack_delay == 0) out_ack = seen_req;
        else ack_cnt = ack_delay;
      end else if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) out_ack = seen_req;
      end
    end
  endtask

  task automatic randomize_data();
    for (int i = 0; i < NREQ; i++) in_data[i*DATA_W +: DATA_W] = $urandom;
  endtask

  task automatic do_reset();
    auto_ack = 1'b0;
    ack_cnt  = 0;
    in_valid = '0;
    tick();
    extReset = 1'b0;
    out_ack  = 1'b0;
    seen_req = 1'b0;
    tick();
    tick();
    #1 extReset = 1'b1;
  endtask

  task automatic test_reset();
    extReset = 1'b0;
    in_valid = '1;
    out_ack  = 1'b0;
    randomize_data();
    #12;
    total++;
    if (in_ready !== '0) $display("FAIL rst_ready: got %b want 0", in_ready);
    else passed++;
    total++;
    if (out_req !== 1'b0 || out_src !== '0)
      $display("FAIL rst_req_src: got %b/%0d want 0/0", out_req, out_src);
    else passed++;
    total++;
    if (out_data !== '0) $display("FAIL rst_data: got %h want 0", out_data);
    else passed++;
    total++;
    if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err);
    else passed++;
    tick();
    #1 extReset = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== oh(0)) $display("FAIL rst_first_grant: got %b want %b", in_ready, oh(0));
    else passed++;
    in_valid = '0;
    tick();
  endtask

  task automatic test_rr_order();
    int ptr = NREQ - 1;
    int ng  = 0;
    int g;
    logic [DATA_W-1:0] dat;
    do_reset();
    in_valid  = '1;
    randomize_data();
    auto_ack  = 1'b1;
    ack_delay = 3;
    for (int c = 0; c < 80 && ng < 5; c++) begin
      @(negedge clk);
      if (in_ready !== '0) begin
        g = rr_pick(ptr, in_valid);
        total++;
        if (in_ready !== oh(g)) $display("FAIL rr_grant%0d: got %b want %b", ng, in_ready, oh(g));
        else passed++;
        ptr = g;
        dat = in_data[g*DATA_W +: DATA_W];
        tick();
        randomize_data();
        total++;
        if (out_src !== SW'(g) || out_data !== dat)
          $display("FAIL rr_capture%0d: got %0d/%h want %0d/%h", ng, out_src, out_data, g, dat);
        else passed++;
        tick();
        total++;
        if (out_req !== logic'((ng + 1) % 2))
          $display("FAIL rr_req%0d: got %b want %b", ng, out_req, (ng + 1) % 2);
        else passed++;
        ng++;
      end else begin
        tick();
      end
    end
    total++;
    if (ng != 5) $display("FAIL rr_count: got %0d grants want 5", ng);
    else passed++;
  endtask

  task automatic test_single();
    int ng = 0;
    int last_e = 0;
    logic [DATA_W-1:0] dat;
    do_reset();
    in_valid  = 4'b0100;
    randomize_data();
    auto_ack  = 1'b1;
    ack_delay = 0;
    for (int c = 0; c < 60 && ng < 4; c++) begin
      @(negedge clk);
      if (in_ready !== '0) begin
        total++;
        if (in_ready !== oh(2)) $display("FAIL single_grant: got %b want %b", in_ready, oh(2));
        else passed++;
        // Accept, launch, SYNC_STAGES ack flops, WAIT_ACK exit, one IDLE cycle.
        if (ng > 0) begin
          total++;
          if (cyc + 1 - last_e != 3 + SYNC_STAGES)
            $display("FAIL single_gap: got %0d want %0d", cyc + 1 - last_e, 3 + SYNC_STAGES);
          else passed++;
        end
        last_e = cyc + 1;
        dat = in_data[2*DATA_W +: DATA_W];
        tick();
        randomize_data();
        total++;
        if (out_src !== SW'(2) || out_data !== dat)
          $display("FAIL single_capture: got %0d/%h want 2/%h", out_src, out_data, dat);
        else passed++;
        ng++;
      end else begin
        tick();
      end
    end
    total++;
    if (ng != 4) $display("FAIL single_count: got %0d want 4", ng);
    else passed++;
  endtask

  task automatic test_ack_withheld();
    logic [DATA_W-1:0] dat;
    bit got = 1'b0;
    do_reset();
    in_valid = '1;
    randomize_data();
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (in_ready !== '0) got = 1'b1;
      else tick();
    end
    total++;
    if (!got || in_ready !== oh(0)) $display("FAIL hold_grant: got %b want %b", in_ready, oh(0));
    else passed++;
    dat = in_data[DATA_W-1:0];
    tick();
    tick();
    for (int c = 0; c < 10; c++) begin
      randomize_data();
      in_valid = NREQ'($urandom);
      @(negedge clk);
      total++;
      if (in_ready !== '0) $display("FAIL hold_ready: got %b want 0", in_ready);
      else passed++;
      total++;
      if (out_data !== dat) $display("FAIL hold_data: got %h want %h", out_data, dat);
      else passed++;
      total++;
      if (out_req !== 1'b1) $display("FAIL hold_req: got %b want 1", out_req);
      else passed++;
      tick();
    end
    in_valid = '1;
    out_ack  = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 3 + SYNC_STAGES + 2 && !got; c++) begin
      @(negedge clk);
      if (in_ready !== '0) got = 1'b1;
      else tick();
    end
    total++;
    if (!got || in_ready !== oh(1)) $display("FAIL hold_release: got %b want %b", in_ready, oh(1));
    else passed++;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_valid = 4'b0100;
    randomize_data();
    @(negedge clk);
    total++;
    if (in_ready !== oh(2)) $display("FAIL mid_grant: got %b want %b", in_ready, oh(2));
    else passed++;
    tick();
    tick();
    in_valid = '1;
    #2 extReset = 1'b0;
    #1;
    total++;
    if (out_req !== 1'b0 || in_ready !== '0)
      $display("FAIL mid_reset: got req %b ready %b want 0/0", out_req, in_ready);
    else passed++;
    total++;
    if (out_src !== '0 || out_data !== '0)
      $display("FAIL mid_clear: got %0d/%h want 0/0", out_src, out_data);
    else passed++;
    out_ack  = 1'b0;
    seen_req = 1'b0;
    tick();
    #1 extReset = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== oh(0)) $display("FAIL mid_next: got %b want %b", in_ready, oh(0));
    else passed++;
    tick();
  endtask

  task automatic test_timeout();
    logic exp;
    do_reset();
    in_valid = 4'b0001;
    @(negedge clk);
    total++;
    if (in_ready !== oh(0)) $display("FAIL tmo_grant: got %b want %b", in_ready, oh(0));
    else passed++;
    tick();
    in_valid = '0;
    tick();
    for (int k = 1; k <= TMO + 6; k++) begin
      @(negedge clk);
      exp = TEN && (k > TMO);
      total++;
      if (err !== exp) $display("FAIL tmo_err%0d: got %b want %b", k, err, exp);
      else passed++;
      tick();
    end
    do_reset();
    @(negedge clk);
    total++;
    if (err !== 1'b0) $display("FAIL tmo_clear: got %b want 0", err);
    else passed++;
  endtask

  task automatic test_spurious();
    bit got = 1'b0;
    do_reset();
    out_ack = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if (in_ready !== '0 || out_req !== 1'b0)
        $display("FAIL spur_idle: got ready %b req %b want 0/0", in_ready, out_req);
      else passed++;
      tick();
    end
    out_ack = 1'b0;
    tick();
    tick();
    tick();
    in_valid = 4'b1000;
    @(negedge clk);
    total++;
    if (in_ready !== oh(3)) $display("FAIL spur_grant: got %b want %b", in_ready, oh(3));
    else passed++;
    tick();
    in_valid = '1;
    tick();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if (in_ready !== '0 || out_req !== 1'b1)
        $display("FAIL spur_wait: got ready %b req %b want 0/1", in_ready, out_req);
      else passed++;
      tick();
    end
    out_ack = 1'b1;
    for (int c = 0; c < 3 + SYNC_STAGES + 2 && !got; c++) begin
      @(negedge clk);
      if (in_ready !== '0) got = 1'b1;
      else tick();
    end
    total++;
    if (!got || in_ready !== oh(0)) $display("FAIL spur_done: got %b want %b", in_ready, oh(0));
    else passed++;
    tick();
  endtask

  task automatic test_random();
    int   ptr = NREQ - 1;
    int   next_ok = 0;
    int   pend_edge = 0;
    int   g;
    bit   pend = 1'b0;
    logic req_par = 1'b0;
    logic [NREQ-1:0]   exp_r;
    logic [DATA_W-1:0] dat;
    do_reset();
    auto_ack = 1'b1;
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
      randomize_data();
      @(negedge clk);
      if (pend && cyc >= pend_edge) begin
        req_par = ~req_par;
        pend = 1'b0;
      end
      total++;
      if (out_req !== req_par) $display("FAIL rnd_req@%0d: got %b want %b", cyc, out_req, req_par);
      else passed++;
      g = (cyc + 1 >= next_ok && in_valid != '0) ? rr_pick(ptr, in_valid) : -1;
      exp_r = (g < 0) ? '0 : oh(g);
      total++;
      if (in_ready !== exp_r) $display("FAIL rnd_ready@%0d: got %b want %b", cyc, in_ready, exp_r);
      else passed++;
      if (g >= 0) begin
        dat = in_data[g*DATA_W +: DATA_W];
        ack_delay = $urandom_range(0, 3);
        ptr = g;
        next_ok = cyc + 1 + 3 + SYNC_STAGES + ack_delay;
        pend = 1'b1;
        pend_edge = cyc + 2;
        tick();
        total++;
        if (out_src !== SW'(g) || out_data !== dat)
          $display("FAIL rnd_capture@%0d: got %0d/%h want %0d/%h", cyc, out_src, out_data, g, dat);
        else passed++;
      end else begin
        tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_rr_order();
    test_single();
    test_ack_withheld();
    test_reset_mid();
    test_timeout();
    test_spurious();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
